// File: rtl/sqrt_pkg.sv
// Shared types and elaboration helpers for the iterative square root unit.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

  function automatic bit sqrt_width_ok(int w);
    return (w >= 4) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/interface_sqrt_iter.sv
// Signal bundle for sqrt_iter; rem is present only when SQRT_REM_EN is defined.
interface interface_sqrt_iter #(
  parameter int WIDTH = 16
);
  localparam int RW = WIDTH / 2;

  bit               clock;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] valor;
  logic             busy;
  logic             endop;
  logic [RW-1:0]    sqrt;
`ifdef SQRT_REM_EN
  logic [RW:0]      rem;
`endif
endinterface

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: consumes one operand bit pair and
// produces one root bit.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int RW = 8
) (
  input  logic [RW+1:0] r,
  input  logic [RW-1:0] root,
  input  logic [1:0]    pair,
  output logic [RW+1:0] r_next,
  output logic [RW-1:0] root_next
);

  logic [RW+1:0] r_sh;
  logic [RW+1:0] trial;
  logic          ge;
  logic          unused_r_top;

  // While iterating, r <= 2*root < 2^RW, so the top two bits are always zero
  // and the shift cannot lose information.
  assign unused_r_top = ^r[RW+1:RW];
  assign r_sh         = {r[RW-1:0], pair};
  assign trial        = {root, 2'b01};
  assign ge           = (r_sh >= trial);
  assign r_next       = ge ? (r_sh - trial) : r_sh;
  assign root_next    = {root[RW-2:0], ge};

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root, one root bit per clock with start/busy/endop
// handshake. Define SQRT_REM_EN to add the registered remainder output rem.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int RW    = WIDTH / 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] valor,
  output logic             busy,
  output logic             endop,
  output logic [RW-1:0]    sqrt
`ifdef SQRT_REM_EN
  ,
  output logic [RW:0]      rem
`endif
);

  localparam int CW = $clog2(RW);
  localparam logic [CW-1:0] CNT_INIT = CW'(RW - 1);

  generate
    if (!sqrt_width_ok(WIDTH)) begin : g_bad_width
      $error("sqrt_iter: WIDTH must be even and at least 4");
    end
  endgenerate

  sqrt_state_t      state_q;
  sqrt_state_t      state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;
  logic [RW+1:0]    r;
  logic [RW-1:0]    root;
  logic [RW+1:0]    r_next;
  logic [RW-1:0]    root_next;

  sqrt_step #(
    .RW(RW)
  ) u_step (
    .r        (r),
    .root     (root),
    .pair     (opnd[WIDTH-1:WIDTH-2]),
    .r_next   (r_next),
    .root_next(root_next)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // busy/endop are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      endop   <= 1'b0;
      sqrt    <= '0;
      cnt     <= '0;
      opnd    <= '0;
      r       <= '0;
      root    <= '0;
`ifdef SQRT_REM_EN
      rem     <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
      endop   <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            opnd <= valor;
            r    <= '0;
            root <= '0;
            cnt  <= CNT_INIT;
          end
        end
        CALC: begin
          opnd <= {opnd[WIDTH-3:0], 2'b00};
          r    <= r_next;
          root <= root_next;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            sqrt <= root_next;
`ifdef SQRT_REM_EN
            rem  <= r_next[RW:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sqrt_iter.md
# sqrt_iter

Parametrised iterative integer square root unit, the successor to the fixed-width `sqrt` core. It computes `floor(sqrt(valor))` for an unsigned operand of configurable even width, producing one result bit per clock. It adds a start/busy handshake and an optional remainder output. It sits behind the same interface-driven SV testbench flow as `sqrt` and keeps the `clock`/`reset`/`valor`/`sqrt`/`endop` port naming.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be even and ≥ 4; elaboration error otherwise.
- `RW`, derived as WIDTH/2, not overridable: root width.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request. Sampled only in IDLE.
- `valor`  in  WIDTH: unsigned operand, captured on the edge that accepts `start`.
- `busy`  out  1: high in CALC and DONE.
- `endop`  out  1: one-cycle pulse, high in DONE.
- `sqrt`  out  RW: integer root. Holds its value until the next accepted `start`.
- `rem`  out  RW+1: `valor − sqrt²`. Present only with `SQRT_REM_EN`.

## Operation
- FSM states IDLE, CALC, DONE.
- **IDLE → CALC** when `start`=1:
  - load operand register ← `valor`
  - root ← 0, partial remainder ← 0, iteration counter ← RW−1
- **CALC**, one bit pair per cycle, MSB pair first:
  - r ← (r<<2) | top two operand bits; operand shifts left 2
  - t = (root<<2) | 1
  - if r ≥ t: r ← r − t, root ← (root<<1)|1; else root ← root<<1
- **CALC → DONE** on the edge completing the iteration with counter = 0. The counter decrements each CALC cycle.
- **DONE → IDLE** unconditionally after one cycle.
- Widths:
  - partial remainder register is RW+2 bits, and no overflow is possible in that width
  - comparison is unsigned
  - `rem` is the low RW+1 bits of the final r
- `sqrt`/`rem` registers update on the CALC→DONE edge only, so intermediate root values are never visible.
- `start` during CALC or DONE is ignored and `valor` is not sampled. No queuing.
- `start` held high continuously: a new operation is accepted on the first IDLE cycle after DONE.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycles 1..RW: CALC.
- Cycle RW+1: DONE, `endop`=1 and results valid.
- Cycle RW+2: IDLE, earliest next accept.
- Latency from accept to `endop` is RW+1 cycles. Throughput is one result per RW+2 cycles.
- Reset values: state IDLE, `busy`=0, `endop`=0, `sqrt`=0, `rem`=0, internal registers 0.
- Reset mid-CALC or in DONE:
  - next cycle is IDLE with all outputs at reset values
  - no `endop` pulse
  - in-flight operation discarded
- `reset` and `start` high in the same cycle: reset wins and `start` is dropped.
- `sqrt`, `rem`, `busy` and `endop` are registered outputs; none is combinational from inputs.

## Configuration
- `SQRT_REM_EN` defined: `rem` port exists and is driven as above.
- `SQRT_REM_EN` undefined:
  - `rem` port is absent
  - partial remainder is still computed internally, since the algorithm needs it
  - only the output register and port are removed
- `sqrt`, `endop` and timing are identical in both builds.

## Structure
- `sqrt_pkg` holds:
  - `sqrt_state_t` enum (IDLE, CALC, DONE)
  - width-check function `sqrt_width_ok(int w)`, used in elaboration assertions
- Sub-module `sqrt_step`: purely combinational single iteration.
  - inputs: r, root, next bit pair
  - outputs: new r, new root
  - parametrised by RW
- Top `sqrt_iter` holds the FSM, counter, operand shifter and output registers, and instantiates one `sqrt_step`.
- Interface `interface_sqrt_iter` carries `clock` (bit), `reset`, `start`, `valor`, `busy`, `endop`, `sqrt`, and `rem` under the macro. It is used by the top-level testbench module with `.*` binding.

## Test plan
- WIDTH=16, `valor`=144, `start` 1 cycle → `endop` exactly 9 cycles after accept, `sqrt`=12, `rem`=0.
- WIDTH=16, `valor`=65535 → `sqrt`=255, `rem`=510; `valor`=0 → `sqrt`=0, `rem`=0; `valor`=17 → `sqrt`=4, `rem`=1.
- WIDTH=8, `valor`=200 → `sqrt`=14, `rem`=4, `endop` 5 cycles after accept.
- Accept `valor`=100, then pulse `start` with `valor`=49 during CALC → result stays 10, single `endop`, no second operation.
- `reset` asserted in the 4th CALC cycle of `valor`=1000 → next cycle IDLE, `busy`=0, `sqrt`=0, no `endop`. A fresh `start` with 1000 → `sqrt`=31, `rem`=39.
- `start` held high across 3 operations with `valor` 81, 64, 25 → results 9, 8, 5, `endop` pulses spaced RW+2 = 10 cycles apart.
